// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter that sequences one single-cycle RAM access per accepted request
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state, state_nxt;
    logic              sel_q, we_q, last_q, win, grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    // On a tie the port that did not win last time takes the grant
    always_comb begin
        win       = (req_0 && req_1) ? ~last_q : req_1;
        grant     = (state == IDLE) && (req_0 || req_1);
        state_nxt = grant ? ACCESS : (state == ACCESS) ? RESP : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sel_q   <= win;
                we_q    <= win ? we_1 : we_0;
                addr_q  <= win ? addr_1 : addr_0;
                wdata_q <= win ? wdata_1 : wdata_0;
                last_q  <= win;
            end
            if (state == ACCESS && !we_q) rdata_q <= mem_rdata;
        end
    end
    assign gnt_0     = grant & ~win;
    assign gnt_1     = grant & win;
    assign rvalid_0  = (state == RESP) & ~sel_q;
    assign rvalid_1  = (state == RESP) & sel_q;
    assign busy      = state != IDLE;
    assign mem_read  = (state == ACCESS) & ~we_q;
    assign mem_write = (state == ACCESS) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32;
    logic          clk = 1'b0, rst_n = 1'b0, preload = 1'b1;
    logic          req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
    logic [AW-1:0] addr_0 = '0, addr_1 = '0;
    logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, busy, mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;
    logic [DW-1:0] ram [256];
    int            checks = 0, errors = 0, cyc = 0;
    int            g_port[$], g_cyc[$];
    int            rv0_cnt = 0, rv1_cnt = 0, wr_cnt = 0;
    int            c0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1),
        .rdata(rdata), .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? ram[mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram[8'h10] <= 32'hDEADBEEF;
            ram[8'h07] <= 32'hAAAA5555;
        end else if (mem_write) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Reference model: a request's life is "granted, then one access cycle, then one response cycle"
    int            m_phase = 0;
    logic          m_sel = 0, m_we = 0, m_last = 1, m_win;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl", 64'({gnt_0, gnt_1, rvalid_0, rvalid_1, busy, mem_read, mem_write}), 64'(0));
            m_phase = 0; m_sel = 0; m_we = 0; m_last = 1;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            m_win = (req_0 && req_1) ? !m_last : req_1;
            chk("gnt", 64'({gnt_1, gnt_0}),
                (m_phase == 0 && (req_0 || req_1)) ? (m_win ? 64'd2 : 64'd1) : 64'd0);
            chk("rvalid", 64'({rvalid_1, rvalid_0}), m_phase == 2 ? (m_sel ? 64'd2 : 64'd1) : 64'd0);
            chk("mem_rw", 64'({mem_write, mem_read}), m_phase == 1 ? (m_we ? 64'd2 : 64'd1) : 64'd0);
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("rdata", 64'(rdata), 64'(m_rdata));
            if (gnt_0) begin g_port.push_back(0); g_cyc.push_back(cyc); end
            if (gnt_1) begin g_port.push_back(1); g_cyc.push_back(cyc); end
            if (rvalid_0) rv0_cnt++;
            if (rvalid_1) rv1_cnt++;
            if (mem_write) wr_cnt++;
            if (m_phase == 0 && (req_0 || req_1)) begin
                m_sel   = m_win;
                m_we    = m_win ? we_1 : we_0;
                m_addr  = m_win ? addr_1 : addr_0;
                m_wdata = m_win ? wdata_1 : wdata_0;
                m_last  = m_win;
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (!m_we) m_rdata = ram[m_addr[7:0]];
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        g_port.delete();
        g_cyc.delete();
    endtask

    initial begin
        repeat (2) step();
        preload = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rdata", 64'(rdata), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        step();

        // Port 0 read of 0x10
        clear_log();
        req_0 = 1; we_0 = 0; addr_0 = 32'h10;
        #1;
        chk("t1_gnt0", 64'({gnt_0, gnt_1}), 64'd2);
        step();
        req_0 = 0; addr_0 = '0;
        chk("t1_mem_read", 64'({mem_read, mem_write}), 64'd2);
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        step();
        chk("t1_rvalid0", 64'({rvalid_0, rvalid_1}), 64'd2);
        chk("t1_rdata", 64'(rdata), 64'hDEADBEEF);
        step();

        // Port 1 write 0x5 then read back, req held high
        clear_log();
        req_1 = 1; we_1 = 1; addr_1 = 32'h5; wdata_1 = 32'h12345678;
        step();
        chk("t2_mem_write", 64'(mem_write), 64'(1));
        we_1 = 0;
        step();
        chk("t2_write_len", 64'(mem_write), 64'(0));
        chk("t2_rvalid1", 64'(rvalid_1), 64'(1));
        step();
        step();
        req_1 = 0;
        step();
        chk("t2_readback", 64'(rdata), 64'h12345678);
        chk("t2_rvalid1_rd", 64'(rvalid_1), 64'(1));
        chk("t2_ngnt", 64'(g_port.size()), 64'(2));
        if (g_port.size() == 2) chk("t2_gap", 64'(g_cyc[1] - g_cyc[0]), 64'(3));
        step();

        // Contention from last=1: expect 0,1,0,1 spaced by 3
        clear_log();
        req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 32'h10; addr_1 = 32'h5;
        repeat (12) step();
        req_0 = 0; req_1 = 0;
        chk("t3_ngnt", 64'(g_port.size()), 64'(4));
        if (g_port.size() == 4) begin
            chk("t3_order", 64'({g_port[0][3:0], g_port[1][3:0], g_port[2][3:0], g_port[3][3:0]}), 64'h0101);
            chk("t3_gap", 64'(g_cyc[3] - g_cyc[0]), 64'(9));
        end
        step();

        // Starvation: port 0 persistent, port 1 arrives during port 0's access
        clear_log();
        req_0 = 1;
        step();
        req_1 = 1;
        repeat (8) step();
        req_0 = 0; req_1 = 0;
        chk("t4_ngnt", 64'(g_port.size()), 64'(3));
        if (g_port.size() == 3)
            chk("t4_order", 64'({g_port[0][3:0], g_port[1][3:0], g_port[2][3:0]}), 64'h010);
        step();

        // Cancellation: req_1 pulsed only while busy
        clear_log();
        c0 = rv1_cnt;
        req_0 = 1;
        step();
        req_0 = 0; req_1 = 1;
        step();
        req_1 = 0;
        repeat (4) step();
        chk("t5_ngnt", 64'(g_port.size()), 64'(1));
        if (g_port.size() == 1) chk("t5_port", 64'(g_port[0]), 64'(0));
        chk("t5_no_rvalid1", 64'(rv1_cnt - c0), 64'(0));

        // Reset during the access cycle of a write to 0x7
        clear_log();
        c0 = rv0_cnt;
        req_0 = 1; we_0 = 1; addr_0 = 32'h7; wdata_0 = 32'h55;
        step();
        req_0 = 0; we_0 = 0;
        chk("t6_write_on", 64'(mem_write), 64'(1));
        #1 rst_n = 0;
        #1;
        chk("t6_write_drop", 64'({mem_write, busy, rvalid_0, rvalid_1}), 64'(0));
        step();
        step();
        rst_n = 1;
        #1;
        chk("t6_ram7", 64'(ram[8'h07]), 64'hAAAA5555);
        chk("t6_no_rvalid", 64'(rv0_cnt - c0), 64'(0));
        req_0 = 1; req_1 = 1; we_1 = 0; addr_1 = 32'h5;
        #1;
        chk("t6_tie_gnt0", 64'({gnt_0, gnt_1}), 64'd2);
        step();
        req_0 = 0; req_1 = 0;
        repeat (3) step();
        chk("t6_total_writes", 64'(wr_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
